// File: rtl/dif_cascade.sv
// Multi-channel backward-difference cascade producing orders 1..ORDER per accepted sample.
// Define DIF_SAT_EN to clamp each order result to DW bits (otherwise two's-complement wrap).
module dif_cascade #(
  parameter  int DW    = 13,
  parameter  int ORDER = 3,
  parameter  int CH    = 1,
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_dif,
  input  logic                clr_ch,
  input  logic [CW-1:0]       ch_id,
  input  logic [DW-1:0]       current_data,
  output logic [ORDER*DW-1:0] dif_data,
  output logic [CW-1:0]       dif_ch,
  output logic [ORDER-1:0]    dif_vld_mask,
  output logic [ORDER-1:0]    dif_sat,
  output logic                dif_finish
);

  localparam int IW   = DW + ORDER;
  localparam int NCH  = 1 << CW;
  localparam int CNTW = $clog2(ORDER + 1);
  localparam logic [CW:0]     CH_L    = CH[CW:0];
  localparam logic [CNTW-1:0] ORDER_C = ORDER[CNTW-1:0];

  // Storage covers the full ch_id range; slots at or above CH are never written.
  logic [DW-1:0]           hist_q [NCH][ORDER];
  logic [DW-1:0]           hist_d [NCH][ORDER];
  logic [CNTW-1:0]         cnt_q  [NCH];
  logic [CNTW-1:0]         cnt_d  [NCH];

  logic [ORDER*DW-1:0]     dif_data_q, dif_data_d;
  logic [CW-1:0]           dif_ch_q, dif_ch_d;
  logic [ORDER-1:0]        dif_vld_mask_q, dif_vld_mask_d;
  logic [ORDER-1:0]        dif_sat_q, dif_sat_d;
  logic                    dif_finish_q, dif_finish_d;

  logic                    ch_ok_s, acc_s, clr_s;
  logic signed [IW-1:0]    lvl_s [ORDER+1][ORDER+1];
  logic [DW:0]             red_s;

`ifdef DIF_SAT_EN
  // Result MSB is the clip flag; the value is clamped when bits above DW-1 disagree.
  function automatic logic [DW:0] reduce_fn(input logic signed [IW-1:0] v);
    logic ovf;
    ovf = ~((&v[IW-1:DW-1]) | (~|v[IW-1:DW-1]));
    if (ovf) begin
      reduce_fn = v[IW-1] ? {1'b1, 1'b1, {(DW-1){1'b0}}} : {1'b1, 1'b0, {(DW-1){1'b1}}};
    end else begin
      reduce_fn = {1'b0, v[DW-1:0]};
    end
  endfunction
`else
  function automatic logic [DW:0] reduce_fn(input logic [DW-1:0] v);
    reduce_fn = {1'b0, v};
  endfunction
`endif

  // Decode which request this cycle carries; a clear overrides a coincident strobe.
  always_comb begin
    ch_ok_s = ({1'b0, ch_id} < CH_L);
    clr_s   = clr_ch & ch_ok_s;
    acc_s   = en_dif & ~clr_ch & ch_ok_s;
  end

  // Cascade of first differences at DW+ORDER bits; level k, index 0 is the order-k result.
  always_comb begin
    for (int k = 0; k <= ORDER; k++) begin
      for (int i = 0; i <= ORDER; i++) begin
        lvl_s[k][i] = '0;
      end
    end
    lvl_s[0][0] = {{ORDER{current_data[DW-1]}}, current_data};
    for (int i = 1; i <= ORDER; i++) begin
      lvl_s[0][i] = {{ORDER{hist_q[ch_id][i-1][DW-1]}}, hist_q[ch_id][i-1]};
    end
    for (int k = 1; k <= ORDER; k++) begin
      for (int i = 0; i <= ORDER - k; i++) begin
        lvl_s[k][i] = lvl_s[k-1][i] - lvl_s[k-1][i+1];
      end
    end
  end

  // Output next-state: outputs hold unless a sample is accepted.
  always_comb begin
    dif_data_d     = dif_data_q;
    dif_ch_d       = dif_ch_q;
    dif_vld_mask_d = dif_vld_mask_q;
    dif_sat_d      = dif_sat_q;
    dif_finish_d   = 1'b0;
    red_s          = '0;
    if (acc_s) begin
      for (int k = 0; k < ORDER; k++) begin
`ifdef DIF_SAT_EN
        red_s = reduce_fn(lvl_s[k+1][0]);
`else
        red_s = reduce_fn(lvl_s[k+1][0][DW-1:0]);
`endif
        dif_data_d[k*DW +: DW] = red_s[DW-1:0];
        dif_sat_d[k]           = red_s[DW];
        dif_vld_mask_d[k]      = (int'(cnt_q[ch_id]) >= (k + 1));
      end
      dif_ch_d     = ch_id;
      dif_finish_d = 1'b1;
    end else begin
      dif_finish_d = 1'b0;
    end
  end

  // History and warm-up count next-state for the addressed channel only.
  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    if (clr_s) begin
      for (int j = 0; j < ORDER; j++) begin
        hist_d[ch_id][j] = '0;
      end
      cnt_d[ch_id] = '0;
    end else if (acc_s) begin
      hist_d[ch_id][0] = current_data;
      for (int j = 1; j < ORDER; j++) begin
        hist_d[ch_id][j] = hist_q[ch_id][j-1];
      end
      if (cnt_q[ch_id] != ORDER_C) begin
        cnt_d[ch_id] = cnt_q[ch_id] + 1'b1;
      end else begin
        cnt_d[ch_id] = cnt_q[ch_id];
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        for (int j = 0; j < ORDER; j++) begin
          hist_q[c][j] <= '0;
        end
        cnt_q[c] <= '0;
      end
      dif_data_q     <= '0;
      dif_ch_q       <= '0;
      dif_vld_mask_q <= '0;
      dif_sat_q      <= '0;
      dif_finish_q   <= 1'b0;
    end else begin
      hist_q         <= hist_d;
      cnt_q          <= cnt_d;
      dif_data_q     <= dif_data_d;
      dif_ch_q       <= dif_ch_d;
      dif_vld_mask_q <= dif_vld_mask_d;
      dif_sat_q      <= dif_sat_d;
      dif_finish_q   <= dif_finish_d;
    end
  end

  assign dif_data     = dif_data_q;
  assign dif_ch       = dif_ch_q;
  assign dif_vld_mask = dif_vld_mask_q;
  assign dif_sat      = dif_sat_q;
  assign dif_finish   = dif_finish_q;

endmodule

// File: tb/tb_dif_cascade.sv
// Directed bench for dif_cascade: a single-channel instance (A) and a three-channel instance (B).
module tb_dif_cascade;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        en_a = 1'b0, clr_a = 1'b0;
  logic [0:0]  ch_a = 1'b0;
  logic [12:0] d_a = 13'd0;
  logic [38:0] data_a;
  logic [0:0]  och_a;
  logic [2:0]  vld_a, sat_a;
  logic        fin_a;

  logic        en_b = 1'b0, clr_b = 1'b0;
  logic [1:0]  ch_b = 2'd0;
  logic [12:0] d_b = 13'd0;
  logic [38:0] data_b;
  logic [1:0]  och_b;
  logic [2:0]  vld_b, sat_b;
  logic        fin_b;

  int n_tests = 0;
  int n_fail  = 0;

  dif_cascade #(.DW(13), .ORDER(3), .CH(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en_dif(en_a), .clr_ch(clr_a), .ch_id(ch_a),
    .current_data(d_a), .dif_data(data_a), .dif_ch(och_a),
    .dif_vld_mask(vld_a), .dif_sat(sat_a), .dif_finish(fin_a)
  );

  dif_cascade #(.DW(13), .ORDER(3), .CH(3)) u_b (
    .clk(clk), .rst_n(rst_n), .en_dif(en_b), .clr_ch(clr_b), .ch_id(ch_b),
    .current_data(d_b), .dif_data(data_b), .dif_ch(och_b),
    .dif_vld_mask(vld_b), .dif_sat(sat_b), .dif_finish(fin_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ord(input logic [38:0] d, input int k);
    logic [12:0] f;
    f = d[(k-1)*13 +: 13];
    return int'($signed(f));
  endfunction

  task automatic chk_res(input string tag, input logic [38:0] d, input int e1, input int e2, input int e3);
    chk({tag, ".o1"}, ord(d, 1), e1);
    chk({tag, ".o2"}, ord(d, 2), e2);
    chk({tag, ".o3"}, ord(d, 3), e3);
  endtask

  task automatic op_a(input logic en, input logic ch, input int v);
    en_a = en; ch_a = ch; d_a = 13'(v);
    @(posedge clk); #1;
    en_a = 1'b0; ch_a = 1'b0;
  endtask

  task automatic op_b(input logic en, input logic clr, input int ch, input int v);
    en_b = en; clr_b = clr; ch_b = 2'(ch); d_b = 13'(v);
    @(posedge clk); #1;
    en_b = 1'b0; clr_b = 1'b0;
  endtask

  int sq[5]  = '{0, 1, 4, 9, 16};
  int r1[5]  = '{0, 1, 3, 5, 7};
  int r2[5]  = '{0, 1, 2, 2, 2};
  int r3[5]  = '{0, 1, 1, 0, 0};
  int rm[5]  = '{0, 1, 3, 7, 7};
  int ich[6] = '{0, 1, 0, 1, 0, 1};
  int iv[6]  = '{10, 5, 20, 5, 30, 5};
  int ie[6]  = '{10, 5, 10, 0, 10, 0};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst.data", int'(data_a == 39'd0), 1);
    chk("rst.ch", int'(och_a), 0);
    chk("rst.mask", int'(vld_a), 0);
    chk("rst.sat", int'(sat_a), 0);
    chk("rst.fin", int'(fin_a), 0);
    chk("rst.fin_b", int'(fin_b), 0);

    // Ramp of squares, back-to-back on the same channel.
    for (int i = 0; i < 5; i++) begin
      op_a(1'b1, 1'b0, sq[i]);
      chk($sformatf("ramp%0d.fin", i), int'(fin_a), 1);
      chk_res($sformatf("ramp%0d", i), data_a, r1[i], r2[i], r3[i]);
      chk($sformatf("ramp%0d.mask", i), int'(vld_a), rm[i]);
      chk($sformatf("ramp%0d.sat", i), int'(sat_a), 0);
    end
    @(posedge clk); #1;
    chk("ramp.fin_drop", int'(fin_a), 0);
    chk("ramp.hold", ord(data_a, 1), 7);

    // Out-of-range channel on the single-channel instance.
    op_a(1'b1, 1'b1, 100);
    chk("a_inv.fin", int'(fin_a), 0);
    chk("a_inv.hold", ord(data_a, 1), 7);
    op_a(1'b1, 1'b0, 25);
    chk_res("a_after_inv", data_a, 9, 2, 0);

    // Interleaved channels on B.
    for (int i = 0; i < 6; i++) begin
      op_b(1'b1, 1'b0, ich[i], iv[i]);
      chk($sformatf("il%0d.fin", i), int'(fin_b), 1);
      chk($sformatf("il%0d.o1", i), ord(data_b, 1), ie[i]);
      chk($sformatf("il%0d.ch", i), int'(och_b), ich[i]);
    end

    // Clear wins over a coincident strobe; the other channel keeps its history.
    op_b(1'b1, 1'b0, 0, 7);
    chk("clr.pre1", ord(data_b, 1), -23);
    op_b(1'b1, 1'b0, 0, 7);
    chk("clr.pre2", ord(data_b, 1), 0);
    chk("clr.pre2.mask", int'(vld_b), 7);
    op_b(1'b1, 1'b1, 0, 99);
    chk("clr.fin", int'(fin_b), 0);
    chk("clr.hold", ord(data_b, 1), 0);
    op_b(1'b1, 1'b0, 1, 5);
    chk_res("clr.ch1", data_b, 0, 0, 0);
    chk("clr.ch1.mask", int'(vld_b), 7);
    chk("clr.ch1.ch", int'(och_b), 1);
    op_b(1'b1, 1'b0, 0, 7);
    chk_res("clr.ch0", data_b, 7, 7, 7);
    chk("clr.ch0.mask", int'(vld_b), 0);

    // Channel 3 does not exist on B: strobe and clear are both ignored.
    op_b(1'b1, 1'b0, 3, 100);
    chk("inv.fin", int'(fin_b), 0);
    chk("inv.hold", ord(data_b, 1), 7);
    chk("inv.ch", int'(och_b), 0);
    op_b(1'b0, 1'b1, 3, 0);
    chk("inv_clr.fin", int'(fin_b), 0);
    op_b(1'b1, 1'b0, 0, 7);
    chk_res("inv.after", data_b, 0, -7, -14);
    chk("inv.after.mask", int'(vld_b), 1);

    // Full-scale step on fresh channel 2.
    op_b(1'b1, 1'b0, 2, 4095);
    chk_res("ovf0", data_b, 4095, 4095, 4095);
    chk("ovf0.sat", int'(sat_b), 0);
    chk("ovf0.ch", int'(och_b), 2);
    op_b(1'b1, 1'b0, 2, -4096);
`ifdef DIF_SAT_EN
    chk_res("ovf1", data_b, -4096, -4096, -4096);
    chk("ovf1.sat", int'(sat_b), 7);
`else
    chk_res("ovf1", data_b, 1, -4094, 3);
    chk("ovf1.sat", int'(sat_b), 0);
`endif
    chk("ovf1.mask", int'(vld_b), 1);

    // Asynchronous reset mid-stream.
    rst_n = 1'b0;
    #1;
    chk("mrst.data", int'(data_a == 39'd0), 1);
    chk("mrst.mask", int'(vld_a), 0);
    chk("mrst.data_b", int'(data_b == 39'd0), 1);
    chk("mrst.ch_b", int'(och_b), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    op_a(1'b1, 1'b0, 5);
    chk("mrst.fin", int'(fin_a), 1);
    chk_res("mrst.first", data_a, 5, 5, 5);
    chk("mrst.first.mask", int'(vld_a), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
